// File: rtl/input_hub.sv
// input_hub
// Conditions N push-buttons (2-flop synchroniser plus counter debounce with
// sticky press/release flags) and averages periodic 2-axis accelerometer
// samples. Everything is visible through a read-only register window with a
// fixed one-cycle read latency.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset (0 = reset)
//   btn_raw      asynchronous button inputs, one bit per channel
//   accel_x/y    raw unsigned accelerometer samples
//   rd_en        read strobe
//   rd_addr      register index: 0 stable levels, 1 press flags,
//                2 release flags, 3 avg_x, 4 avg_y, 5 update count, 6/7 zero
//   rd_data      registered read data, valid the cycle after rd_en
//   irq          high while any press or release flag is set
//   accel_update one-cycle pulse when the averaged outputs are refreshed
module input_hub #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACCEL_W         = 9,
    parameter int SAMPLE_PERIOD   = 5000,
    parameter int AVG_LOG2        = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [ACCEL_W-1:0] accel_x,
    input  logic [ACCEL_W-1:0] accel_y,
    input  logic               rd_en,
    input  logic [2:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               irq,
    output logic               accel_update
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int ACC_W  = ACCEL_W + AVG_LOG2;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]        CNT_LAST  = 5'((1 << AVG_LOG2) - 1);

    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    logic [NUM_BTN-1:0] stable_r;
    logic [NUM_BTN-1:0] press_r;
    logic [NUM_BTN-1:0] release_r;
    logic [DB_W-1:0]    db_cnt_r [NUM_BTN];

    logic [NUM_BTN-1:0] accept_s;
    logic [NUM_BTN-1:0] rise_s;
    logic [NUM_BTN-1:0] fall_s;
    logic               clr_press_s;
    logic               clr_release_s;

    logic [TICK_W-1:0]  tick_r;
    logic [4:0]         smp_cnt_r;
    logic [ACC_W-1:0]   acc_x_r;
    logic [ACC_W-1:0]   acc_y_r;
    logic [ACCEL_W-1:0] avg_x_r;
    logic [ACCEL_W-1:0] avg_y_r;
    logic [15:0]        upd_cnt_r;
    logic [ACC_W-1:0]   sum_x_s;
    logic [ACC_W-1:0]   sum_y_s;

    logic [31:0]        rd_mux_s;

    // Debounce acceptance: a mismatch that has survived DEBOUNCE_CYCLES-1
    // counted cycles is accepted now and becomes a rise or fall event.
    always_comb begin
        accept_s = {NUM_BTN{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            if ((sync2_r[i] != stable_r[i]) && (db_cnt_r[i] == DB_LAST)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
        end
        rise_s = accept_s & sync2_r;
        fall_s = accept_s & ~sync2_r;
    end

    // Synchroniser chain and per-channel debounce counters / stable levels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r  <= {NUM_BTN{1'b0}};
            sync2_r  <= {NUM_BTN{1'b0}};
            stable_r <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (accept_s[i]) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign clr_press_s   = rd_en && (rd_addr == 3'd1);
    assign clr_release_s = rd_en && (rd_addr == 3'd2);

    // Sticky event flags; a new event wins over a same-cycle read clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_r   <= {NUM_BTN{1'b0}};
            release_r <= {NUM_BTN{1'b0}};
        end else begin
            press_r   <= (press_r & ~{NUM_BTN{clr_press_s}}) | rise_s;
            release_r <= (release_r & ~{NUM_BTN{clr_release_s}}) | fall_s;
        end
    end

    assign irq = (|press_r) | (|release_r);

    // Running sums include the sample being taken this tick.
    assign sum_x_s = acc_x_r + ACC_W'(accel_x);
    assign sum_y_s = acc_y_r + ACC_W'(accel_y);

    // Sample tick, accumulation and truncating average of 2^AVG_LOG2 samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_r       <= {TICK_W{1'b0}};
            smp_cnt_r    <= 5'd0;
            acc_x_r      <= {ACC_W{1'b0}};
            acc_y_r      <= {ACC_W{1'b0}};
            avg_x_r      <= {ACCEL_W{1'b0}};
            avg_y_r      <= {ACCEL_W{1'b0}};
            upd_cnt_r    <= 16'd0;
            accel_update <= 1'b0;
        end else if (tick_r == TICK_LAST) begin
            tick_r <= {TICK_W{1'b0}};
            if (smp_cnt_r == CNT_LAST) begin
                avg_x_r      <= sum_x_s[ACC_W-1:AVG_LOG2];
                avg_y_r      <= sum_y_s[ACC_W-1:AVG_LOG2];
                acc_x_r      <= {ACC_W{1'b0}};
                acc_y_r      <= {ACC_W{1'b0}};
                smp_cnt_r    <= 5'd0;
                upd_cnt_r    <= upd_cnt_r + 16'd1;
                accel_update <= 1'b1;
            end else begin
                acc_x_r      <= sum_x_s;
                acc_y_r      <= sum_y_s;
                smp_cnt_r    <= smp_cnt_r + 5'd1;
                accel_update <= 1'b0;
            end
        end else begin
            tick_r       <= tick_r + TICK_W'(1);
            accel_update <= 1'b0;
        end
    end

    // Register window decode; unused indices read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_addr)
            3'd0:    rd_mux_s = 32'(stable_r);
            3'd1:    rd_mux_s = 32'(press_r);
            3'd2:    rd_mux_s = 32'(release_r);
            3'd3:    rd_mux_s = 32'(avg_x_r);
            3'd4:    rd_mux_s = 32'(avg_y_r);
            3'd5:    rd_mux_s = 32'(upd_cnt_r);
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read data register: loads only on a strobe, otherwise holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= 32'd0;
        end else if (rd_en) begin
            rd_data <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_input_hub.sv
// Directed bench for input_hub with short debounce and sample periods.
module tb_input_hub;

    logic        clock;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [8:0]  accel_x;
    logic [8:0]  accel_y;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        irq;
    logic        accel_update;

    int checks;
    int errors;

    input_hub #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (4),
        .ACCEL_W         (9),
        .SAMPLE_PERIOD   (2),
        .AVG_LOG2        (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .irq          (irq),
        .accel_update (accel_update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle per entry: drive at the negedge, check after the next posedge.
    typedef struct {
        logic        rst;
        logic [3:0]  btn;
        logic        rd;
        logic [2:0]  addr;
        logic        exp_irq;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] btn, input logic rd,
                       input logic [2:0] addr, input logic exp_irq,
                       input logic chk, input logic [31:0] exp_rd);
        vec_t v;
        v.rst = rst; v.btn = btn; v.rd = rd; v.addr = addr;
        v.exp_irq = exp_irq; v.chk = chk; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reset ends on a negedge; the following posedge is cycle 1.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        btn_raw = 4'b0000;
        accel_x = 9'd0;
        accel_y = 9'd0;
        rd_en   = 1'b1;
        rd_addr = 3'd3;

        // Reset state, with a read strobe held active
        repeat (3) @(negedge clock);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_accel_update", {31'd0, accel_update}, 32'h0);

        // Press on bit 0: stable + flag at cycle 6, read clears flag
        add(1'b1, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b1, 32'h0);
        add(1'b0, 4'b0001, 1'b1, 3'd0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 4'b0001, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 4'b0001, 1'b1, 3'd0, 1'b1, 1'b1, 32'h1);
        add(1'b0, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b1, 32'h1);
        add(1'b0, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b1, 32'h0);
        // 3-cycle glitch on bit 2 is rejected
        add(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 4'b0000, 1'b1, 3'd1, 1'b0, 1'b1, 32'h0);
        add(1'b0, 4'b0000, 1'b1, 3'd2, 1'b0, 1'b1, 32'h0);
        // Press bit 2, clear press flag, then release colliding with a reg2 read
        for (int i = 0; i < 5; i++) add(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0100, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 4'b0100, 1'b1, 3'd1, 1'b0, 1'b1, 32'h4);
        for (int i = 0; i < 4; i++) add(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b1, 32'h4);
        add(1'b0, 4'b0000, 1'b1, 3'd2, 1'b1, 1'b1, 32'h0);
        add(1'b0, 4'b0000, 1'b1, 3'd2, 1'b0, 1'b1, 32'h4);
        add(1'b0, 4'b0000, 1'b1, 3'd2, 1'b0, 1'b1, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            btn_raw = vecs[i].btn;
            rd_en   = vecs[i].rd;
            rd_addr = vecs[i].addr;
            cycle();
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            end
        end
        rd_en   = 1'b0;
        btn_raw = 4'b0000;

        // Constant accelerometer input: exactly one update in 8 cycles
        accel_x = 9'd100;
        accel_y = 9'd511;
        do_reset();
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (accel_update) pulses++;
        end
        check("const_pulses", 32'(pulses), 32'd1);
        check("const_pulse_at_8", {31'd0, accel_update}, 32'h1);
        rd_en = 1'b1;
        rd_addr = 3'd3; cycle(); check("const_avg_x", rd_data, 32'd100);
        rd_addr = 3'd4; cycle(); check("const_avg_y", rd_data, 32'd511);
        rd_addr = 3'd5; cycle(); check("const_upd_cnt", rd_data, 32'd1);
        rd_en = 1'b0;

        // Samples 10,11,12,13 average to 46>>2 = 11
        accel_y = 9'd0;
        accel_x = 9'd10;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            accel_x = 9'(10 + (k - 1) / 2);
            cycle();
        end
        check("ramp_pulse", {31'd0, accel_update}, 32'h1);
        rd_en = 1'b1;
        rd_addr = 3'd3; cycle(); check("ramp_avg_x", rd_data, 32'd11);
        rd_addr = 3'd4; cycle(); check("ramp_avg_y", rd_data, 32'd0);
        rd_addr = 3'd7; cycle(); check("addr7_zero", rd_data, 32'd0);
        rd_en = 1'b0;

        // Reset mid-debounce and mid-accumulation
        accel_x = 9'd200;
        accel_y = 9'd300;
        do_reset();
        btn_raw = 4'b0001;
        repeat (5) cycle();
        reset   = 1'b0;
        btn_raw = 4'b0000;
        @(negedge clock);
        check("midrst_rd_data", rd_data, 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rd_en   = 1'b1;
            rd_addr = 3'(k);
            cycle();
            check($sformatf("postrst_rd%0d", k), rd_data, 32'h0);
            check($sformatf("postrst_upd%0d", k), {31'd0, accel_update}, 32'h0);
            check($sformatf("postrst_irq%0d", k), {31'd0, irq}, 32'h0);
        end
        rd_en = 1'b0;
        cycle();
        check("postrst_pulse", {31'd0, accel_update}, 32'h1);
        rd_en = 1'b1;
        rd_addr = 3'd3; cycle(); check("postrst_avg_x", rd_data, 32'd200);
        rd_addr = 3'd4; cycle(); check("postrst_avg_y", rd_data, 32'd300);
        rd_addr = 3'd5; cycle(); check("postrst_upd_cnt", rd_data, 32'd1);
        rd_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
